seq_shifter: RTL and testbench

- Iterative, multi-cycle 16-bit shift unit. It shifts one bit position per clock under a start/busy/done handshake.
- Complements the single-cycle combinational shifter. Adds logical right shift and rotate right alongside left and arithmetic right shifts.
- Sits beside the ALU as the shift/rotate unit for the multi-cycle datapath. The control FSM launches an operation and stalls until done.

---
 rtl/seq_shifter.sv | 115 +++++++++++
 tb/tb_seq_shifter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Iterative shift/rotate unit: moves one bit position per clock under a
// start/busy/done handshake, for the multi-cycle datapath.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; operands captured on the accepting edge
// S_SHIFT | one bit step per edge until the count reaches zero
// S_DONE  | one-cycle completion pulse, result is valid
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       opr_q, opr_d;
    logic [WIDTH-1:0] result_q, result_d;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s,
                                                input logic [1:0] o);
        logic [WIDTH-1:0] r;
        case (o)
            OP_SLL:  r = {s[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, s[WIDTH-1:1]};
            OP_SRA:  r = {s[WIDTH-1], s[WIDTH-1:1]};
            OP_ROR:  r = {s[0], s[WIDTH-1:1]};
            default: r = s;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            opr_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            opr_q    <= opr_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        opr_d    = opr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_d  = data_in;
                    cnt_d   = amount;
                    opr_d   = op;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The count only decrements while nonzero, so it never wraps.
                if (cnt_q != '0) begin
                    sreg_d = shift1(sreg_q, opr_q);
                    cnt_d  = cnt_q - AMT_W'(1);
                end else begin
                    result_d = sreg_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        result = result_q;
        case (state_q)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: expected results and busy lengths are
// queued at launch and compared when done pulses.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  amount = '0;
    logic [1:0]  op = '0;
    logic        busy, done;
    logic [15:0] result;

    seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .amount(amount), .op(op), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        int          busy_len;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input int a, input logic [1:0] o);
        logic signed [15:0] s;
        logic [15:0] r;
        s = d;
        case (o)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = s >>> a;
            default: r = (a == 0) ? d : ((d >> a) | (d << (16 - a)));
        endcase
        return r;
    endfunction

    // Monitor: counts busy cycles and scores each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                exp_t e;
                check_eq("done_single", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    check_eq("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("result", {16'd0, result}, {16'd0, e.res});
                    check_eq("busy_len", busy_cnt, e.busy_len);
                end
                busy_cnt = 0;
                done_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic launch(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o);
        exp_t e;
        @(negedge clk);
        data_in = d;
        amount  = a;
        op      = o;
        start   = 1'b1;
        e.res      = model(d, int'(a), o);
        e.busy_len = int'(a) + 1;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'($urandom);
        amount  = 4'($urandom);
        op      = 2'($urandom);
    endtask

    task automatic wait_done();
        int prev;
        bit seen;
        prev = done_cnt;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != prev) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check_eq("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o);
        launch(d, a, o);
        wait_done();
    endtask

    initial begin
        exp_t e;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        rst_n = 1'b1;

        run(16'h0001, 4'd4, 2'b00);
        run(16'h8000, 4'd15, 2'b10);
        run(16'h4000, 4'd14, 2'b10);
        run(16'h8000, 4'd15, 2'b01);
        run(16'h0001, 4'd1, 2'b11);
        run(16'hA5C3, 4'd4, 2'b11);
        run(16'hBEEF, 4'd0, 2'b00);
        check_eq("plan_ror", {16'd0, model(16'hA5C3, 4, 2'b11)}, 32'h3A5C);
        for (int i = 0; i < 6; i++)
            run(16'($urandom), 4'($urandom), 2'($urandom));

        // Ignored start while busy, then start held high through DONE.
        launch(16'h00FF, 4'd8, 2'b00);
        @(negedge clk);
        data_in = 16'h1234;
        op      = 2'b01;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        @(negedge clk);
        data_in = 16'h1234;
        amount  = 4'd3;
        op      = 2'b01;
        start   = 1'b1;
        e.res      = 16'h0246;
        e.busy_len = 4;
        sb.push_back(e);
        wait_done();
        @(negedge clk);
        #1;
        check_eq("hold_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("hold_accept_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done();

        // Asynchronous abort mid-operation.
        launch(16'hFFFF, 4'd10, 2'b01);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_result", {16'd0, result}, 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        run(16'h0F0F, 4'd2, 2'b11);

        repeat (25) @(negedge clk);
        check_eq("sb_empty", sb.size(), 32'd0);
        check_eq("done_total", done_cnt, 32'd16);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
